// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared constants and helpers for the programmable delay line
package delay_pkg;

    function automatic int delay_dw(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // Out-of-range requests saturate so the tap index is always a real stage.
    function automatic int delay_clamp(input int cfg, input int max_delay);
        if (cfg < 1) return 1;
        if (cfg > max_delay) return max_delay;
        return cfg;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/delay_line_prog_if.sv
// rtl/delay_line_prog_if.sv - stream, control and tap signals of the delay line
interface delay_line_prog_if #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 2,
    parameter int MAX_DELAY = 16
);
    import delay_pkg::*;

    localparam int DW = delay_dw(MAX_DELAY);

    logic                        ce;
    logic                        flush;
    logic                        x_valid;
    logic [WIDTH*CHANNELS-1:0]   x;
    logic                        delay_load;
    logic [DW-1:0]               delay_cfg;
    logic [DW-1:0]               delay_cur;
    logic                        y_valid;
    logic [WIDTH*CHANNELS-1:0]   y;

    modport master (
        output ce, flush, x_valid, x, delay_load, delay_cfg,
        input  delay_cur, y_valid, y
    );

    modport slave (
        input  ce, flush, x_valid, x, delay_load, delay_cfg,
        output delay_cur, y_valid, y
    );
endinterface

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - one {valid, data} register with clock enable and flush
module delay_stage #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Flush clears regardless of ce so stale samples never leak past a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

// File: rtl/delay_line_prog.sv
// rtl/delay_line_prog.sv - programmable-depth multi-channel valid-tagged delay line
module delay_line_prog
    import delay_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 2,
    parameter int MAX_DELAY   = 16,
    parameter int RESET_DELAY = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    delay_line_prog_if.slave    bus
);

    localparam int DW = delay_dw(MAX_DELAY);
    localparam int TW = WIDTH * CHANNELS;
    localparam logic [DW-1:0] CUR_RST = DW'(delay_clamp(RESET_DELAY, MAX_DELAY));

    // Each stage word is {valid, data}; stage 0 takes the live input.
    logic [TW:0]   st [MAX_DELAY];
    logic [DW-1:0] cur;
    logic          tap_valid;
    logic [TW-1:0] tap_data;

    for (genvar i = 0; i < MAX_DELAY; i++) begin : g_stage
        if (i == 0) begin : g_head
            delay_stage #(.W(TW + 1)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .ce    (bus.ce),
                .flush (bus.flush),
                .d     ({bus.x_valid, bus.x}),
                .q     (st[i])
            );
        end else begin : g_body
            delay_stage #(.W(TW + 1)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .ce    (bus.ce),
                .flush (bus.flush),
                .d     (st[i-1]),
                .q     (st[i])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= CUR_RST;
        end else if (bus.delay_load) begin
            cur <= DW'(delay_clamp(int'(bus.delay_cfg), MAX_DELAY));
        end
    end

    // delay_cur is always 1..MAX_DELAY, so exactly one stage matches.
    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (cur == DW'(i + 1)) begin
                tap_valid = st[i][TW];
                tap_data  = st[i][TW-1:0];
            end
        end
    end

    assign bus.delay_cur = cur;
    assign bus.y_valid   = tap_valid;
    assign bus.y         = tap_data;

endmodule

// File: tb/tb_delay_line_prog.sv
// tb/tb_delay_line_prog.sv - scoreboard bench for delay_line_prog
module tb_delay_line_prog;

    localparam int WIDTH     = 8;
    localparam int CHANNELS  = 2;
    localparam int MAX_DELAY = 16;
    localparam int RST_D     = 8;
    localparam int DW        = $clog2(MAX_DELAY + 1);
    localparam int TW        = WIDTH * CHANNELS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    delay_line_prog_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY)) bus ();

    delay_line_prog #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY), .RESET_DELAY(RST_D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cur_d  = RST_D;
    int k      = 0;
    logic [TW:0] sb [$];
    logic [TW:0] got;
    logic [TW:0] exp_v;

    function automatic logic [TW-1:0] pack(input int v);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'(v);
        hi = 8'(v + 100);
        return {hi, lo};
    endfunction

    function automatic int clamp_ref(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > MAX_DELAY) return MAX_DELAY;
        return cfg;
    endfunction

    function automatic logic [TW:0] expect_out();
        if (sb.size() >= cur_d) return sb[sb.size() - cur_d];
        return '0;
    endfunction

    task automatic step(input logic c, input logic f, input logic xv, input logic [TW-1:0] xd,
                        input logic ld = 1'b0, input int cfg = 0);
        bus.ce         = c;
        bus.flush      = f;
        bus.x_valid    = xv;
        bus.x          = xd;
        bus.delay_load = ld;
        bus.delay_cfg  = DW'(cfg);
        @(posedge clk);
        if (f) begin
            sb.delete();
        end else if (c) begin
            sb.push_back({xv, xd});
            if (sb.size() > MAX_DELAY) void'(sb.pop_front());
        end
        if (ld) cur_d = clamp_ref(cfg);
        #1;
        bus.delay_load = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic stream(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b1, pack(k));
            k++;
            got   = {bus.y_valid, bus.y};
            exp_v = expect_out();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL %s[%0d] y got=%h exp=%h", tag, i, got, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({bus.y_valid, bus.y} !== '0) begin
            errors++;
            $display("FAIL reset_y got=%h exp=0", {bus.y_valid, bus.y});
        end
        checks++;
        if (bus.delay_cur !== DW'(RST_D)) begin
            errors++;
            $display("FAIL reset_delay_cur got=%0d exp=%0d", bus.delay_cur, RST_D);
        end
        sb.delete();
        cur_d = RST_D;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        k = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b1, pack(k));
            k++;
            checks++;
            if (i < 7 && bus.y_valid !== 1'b0) begin
                errors++;
                $display("FAIL fill_early_valid[%0d] got=%b exp=0", i, bus.y_valid);
            end else if (i >= 7 && {bus.y_valid, bus.y} !== {1'b1, pack(i - 7)}) begin
                errors++;
                $display("FAIL fill_data[%0d] got=%h exp=%h", i, {bus.y_valid, bus.y}, {1'b1, pack(i - 7)});
            end
        end
    endtask

    task automatic test_stall();
        logic [TW:0] held;
        held = {bus.y_valid, bus.y};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, pack(200 + i));
            checks++;
            if ({bus.y_valid, bus.y} !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, {bus.y_valid, bus.y}, held);
            end
        end
        stream(10, "stall_resume");
    endtask

    task automatic test_flush();
        step(1'b1, 1'b1, 1'b1, pack(k));
        k++;
        checks++;
        if ({bus.y_valid, bus.y} !== '0) begin
            errors++;
            $display("FAIL flush_clear got=%h exp=0", {bus.y_valid, bus.y});
        end
        stream(12, "flush_refill");
    endtask

    task automatic test_delay_change();
        step(1'b1, 1'b0, 1'b1, pack(k), 1'b1, 3);
        k++;
        checks++;
        if (bus.delay_cur !== DW'(3)) begin
            errors++;
            $display("FAIL load3 delay_cur got=%0d exp=3", bus.delay_cur);
        end
        stream(6, "delay3");
        step(1'b1, 1'b0, 1'b1, pack(k), 1'b1, 12);
        k++;
        checks++;
        if (bus.delay_cur !== DW'(12)) begin
            errors++;
            $display("FAIL load12 delay_cur got=%0d exp=12", bus.delay_cur);
        end
        stream(14, "delay12");
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 0);
        checks++;
        if (bus.delay_cur !== DW'(1)) begin
            errors++;
            $display("FAIL clamp0 delay_cur got=%0d exp=1", bus.delay_cur);
        end
        stream(3, "delay1");
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 31);
        checks++;
        if (bus.delay_cur !== DW'(MAX_DELAY)) begin
            errors++;
            $display("FAIL clamp31 delay_cur got=%0d exp=%0d", bus.delay_cur, MAX_DELAY);
        end
        stream(4, "delay16");
    endtask

    task automatic test_sparse();
        logic xv;
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 5);
        for (int i = 0; i < 16; i++) begin
            xv = (i % 4 == 0) || (i % 4 == 3);
            step(1'b1, 1'b0, xv, pack(50 + i));
            got   = {bus.y_valid, bus.y};
            exp_v = expect_out();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL sparse[%0d] y got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        checks++;
        if (bus.y_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_valid got=%b exp=1", bus.y_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.y_valid, bus.y} !== '0 || bus.delay_cur !== DW'(RST_D)) begin
            errors++;
            $display("FAIL areset_immediate y=%h delay_cur=%0d exp y=0 delay_cur=%0d",
                     {bus.y_valid, bus.y}, bus.delay_cur, RST_D);
        end
        sb.delete();
        cur_d = RST_D;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stream(12, "areset_refill");
    endtask

    initial begin
        bus.ce         = 1'b0;
        bus.flush      = 1'b0;
        bus.x_valid    = 1'b0;
        bus.x          = '0;
        bus.delay_load = 1'b0;
        bus.delay_cfg  = '0;
        test_reset();
        test_fill();
        test_stall();
        test_flush();
        test_delay_change();
        test_sparse();
        stream(6, "prefill");
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_line_prog.md
Name: delay_line_prog

Overview:
- Programmable-depth, multi-channel, valid-tagged delay line. It is the next generation of the team's fixed shift-register delay.
- Adds per-sample valid tracking, clock enable (stall), synchronous flush, and a run-time delay select up to MAX_DELAY.
- Sits in datapaths that must re-align streams of differing latency, for example matching the control path to an arithmetic pipeline.

Parameters:
- WIDTH, 8: bits per channel.
- CHANNELS, 2: independent lanes delayed together. Packed, lane k at [k*WIDTH +: WIDTH].
- MAX_DELAY, 16: number of physical stages; maximum delay in cycles. Must be >= 1.
- RESET_DELAY, 8: delay in effect after reset. Clamped into 1..MAX_DELAY.
- DW: localparam, $clog2(MAX_DELAY+1), width of the delay fields.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable; shift occurs only when 1
- flush  in  1  synchronous clear of the pipeline contents
- x_valid  in  1  input sample qualifier
- x  in  WIDTH*CHANNELS  input samples
- delay_load  in  1  one-cycle strobe that loads delay_cfg
- delay_cfg  in  DW  requested delay in cycles
- delay_cur  out  DW  delay currently in effect
- y_valid  out  1  output sample qualifier
- y  out  WIDTH*CHANNELS  delayed samples

Behaviour:
- Storage: MAX_DELAY stages. Each stage holds {valid, data[WIDTH*CHANNELS]}.
- Reset (rst_n=0, asynchronous):
  - All stage data = 0, all stage valid = 0.
  - delay_cur = clamp(RESET_DELAY).
  - Therefore y = 0 and y_valid = 0 while in reset and immediately after.
- Shift (ce=1, flush=0):
  - stage[0] <= {x_valid, x}.
  - stage[i] <= stage[i-1] for i = 1..MAX_DELAY-1.
  - All channels shift in lockstep.
- Stall (ce=0, flush=0): all stages hold. y and y_valid hold because they are a function of the held registers.
- Flush (flush=1): on the next edge all valid bits = 0 and all data = 0, regardless of ce. A simultaneous x_valid sample is dropped. delay_cur is unaffected.
- Output tap:
  - y = stage[delay_cur-1].data and y_valid = stage[delay_cur-1].valid.
  - Combinational mux from registers; no extra register.
- Latency: with ce held 1, a sample presented before edge n appears on y after edge n+delay_cur-1. It is visible during the cycle following the delay_cur-th rising edge, counting edge n as the first.
  - delay_cur=1 gives a one-register delay, identical to a single flop.
- Delay programming:
  - On an edge with delay_load=1: delay_cur <= clamp(delay_cfg).
  - clamp: 0 -> 1; values > MAX_DELAY -> MAX_DELAY; otherwise unchanged.
  - Load is independent of ce and flush and takes effect in the cycle after the strobe.
  - Stage contents are not modified by a load.
  - Increasing the delay re-exposes older samples, so some appear twice.
  - Decreasing it skips samples.
  - Valid bits stay truthful: any stage not yet written since reset or flush shows y_valid = 0.
- Invalid samples still shift; data under valid = 0 is don't-care for consumers but must be 0 after reset or flush.
- Simultaneous events: rst_n dominates all. flush dominates ce. delay_load combines freely with all of them.
- No internal counters; the storage never wraps.

Decomposition:
- Shared package delay_pkg:
  - Function delay_clamp(cfg, max).
  - Localparam idiom for DW.
  - Lane-slice helper constants.
- One sub-module, delay_stage: a single {valid, data} register with async active-low reset, ce, and flush, parameterised by total width.
- delay_line_prog instantiates MAX_DELAY delay_stage instances via generate and adds the tap mux and the delay_cur register.

Test Plan:
- Reset and fill: WIDTH=8, CHANNELS=2, default delay 8. Release rst_n, then drive x=counter (lane0=k, lane1=k+100) with x_valid=1 and ce=1.
  -> y_valid stays 0 for the first 7 cycles after the first shift. First y = {100,0} one cycle after the 8th edge, then increments each cycle.
- Stall: during streaming drive ce=0 for 3 cycles.
  -> y and y_valid frozen for exactly 3 cycles. Sequence resumes with no loss or duplication.
- Flush mid-stream with x_valid=1 on the flush cycle.
  -> Next cycle y_valid=0 and y=0. The flushed-cycle sample never appears. The first post-flush sample appears delay_cur cycles after its entry.
- Delay change: set delay_cfg=3 then 12 via delay_load while streaming.
  -> delay_cur reads 3 then 12 one cycle after each strobe. Output latency measured as 3 and 12. Samples are skipped on the decrease and repeated on the increase.
  -> delay_cfg=0 gives delay_cur=1; delay_cfg=31 with MAX_DELAY=16 gives delay_cur=16.
- Async reset mid-operation: assert rst_n=0 between clock edges while y_valid=1.
  -> y=0, y_valid=0, and delay_cur=8 immediately (no clock edge). They remain so until the refill latency has elapsed after release.
- Sparse valid: x_valid toggles 1,0,0,1 with delay 5.
  -> y_valid reproduces 1,0,0,1 exactly 5 cycles later, with the matching data on the valid cycles.
